// File: rtl/lpcm_arbiter.sv
// Round-robin arbiter granting N LPCM sources bursts of up to MAX_BURST samples on one channel.
// Define LPCM_ARBITER_STATS_EN to add per-requester saturating accepted-sample counters (sample_cnt).
module lpcm_arbiter #(
    parameter int N         = 2,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 16,
    parameter int GAP       = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    input  logic [N-1:0]         in_en,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic                 out_en,
    output logic [WIDTH-1:0]     out_data,
    output logic                 burst_done,
    output logic                 busy
`ifdef LPCM_ARBITER_STATS_EN
    ,
    output logic [N*32-1:0]      sample_cnt
`endif
);

    localparam int IW     = $clog2(N);
    localparam int CW     = $clog2(MAX_BURST + 1);
    localparam int GW     = 4;
    localparam int GAP_LD = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GAP
    } state_t;

    state_t            state_q;
    logic [N-1:0]      gnt_q;
    logic [IW-1:0]     gidx_q;
    logic [IW-1:0]     ptr_q;
    logic [CW-1:0]     cnt_q;
    logic [GW-1:0]     gap_q;
    logic              out_en_q;
    logic [WIDTH-1:0]  out_data_q;
    logic              burst_done_q;

    logic              sel_found;
    logic [IW-1:0]     sel_idx;
    logic [IW:0]       cand;
    logic              accept;
    logic [WIDTH-1:0]  gdata;
    logic [CW-1:0]     cnt_d;
    logic [IW-1:0]     ptr_d;
    logic              burst_end;

    // Rotating priority: first requester at or above ptr, wrapping modulo N.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!sel_found && req[cand[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        accept    = |(gnt_q & in_en);
        gdata     = in_data[gidx_q*WIDTH +: WIDTH];
        cnt_d     = cnt_q + 1'b1;
        ptr_d     = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + 1'b1;
        // A sample presented with req already low is still taken; the burst ends on that same edge.
        burst_end = (state_q == ST_GRANT) &&
                    ((accept && (cnt_d == CW'(MAX_BURST))) || !req[gidx_q]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            gidx_q       <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            gap_q        <= '0;
            out_en_q     <= 1'b0;
            out_data_q   <= '0;
            burst_done_q <= 1'b0;
        end else begin
            out_en_q     <= 1'b0;
            out_data_q   <= '0;
            burst_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sel_found) begin
                        gnt_q   <= N'(1) << sel_idx;
                        gidx_q  <= sel_idx;
                        cnt_q   <= '0;
                        state_q <= ST_GRANT;
                    end else begin
                        gnt_q <= '0;
                    end
                end
                ST_GRANT: begin
                    if (accept) begin
                        out_en_q   <= 1'b1;
                        out_data_q <= gdata;
                        cnt_q      <= cnt_d;
                    end
                    if (burst_end) begin
                        gnt_q        <= '0;
                        burst_done_q <= 1'b1;
                        ptr_q        <= ptr_d;
                        if (GAP > 0) begin
                            gap_q   <= GW'(GAP_LD);
                            state_q <= ST_GAP;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign out_en     = out_en_q;
    assign out_data   = out_data_q;
    assign burst_done = burst_done_q;
    assign busy       = (state_q != ST_IDLE);

`ifdef LPCM_ARBITER_STATS_EN
    logic [N*32-1:0] stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (gnt_q[i] && in_en[i] && (stat_q[i*32 +: 32] != '1)) begin
                    stat_q[i*32 +: 32] <= stat_q[i*32 +: 32] + 32'd1;
                end
            end
        end
    end

    assign sample_cnt = stat_q;
`endif

endmodule

// File: tb/tb_lpcm_arbiter.sv
// Scoreboard bench for lpcm_arbiter (N=2, WIDTH=32, MAX_BURST=4, GAP=1): stimulus pushes expected
// samples and burst records, a negedge monitor pops and compares them.
module tb_lpcm_arbiter;

    localparam int N         = 2;
    localparam int WIDTH     = 32;
    localparam int MAX_BURST = 4;
    localparam int GAP       = 1;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0]       req = '0;
    logic [N-1:0]       gnt;
    logic [N-1:0]       in_en = '0;
    logic [N*WIDTH-1:0] in_data = '0;
    logic               out_en;
    logic [WIDTH-1:0]   out_data;
    logic               burst_done;
    logic               busy;
`ifdef LPCM_ARBITER_STATS_EN
    logic [N*32-1:0]    sample_cnt;
`endif

    always #5 clk = ~clk;

    lpcm_arbiter #(
        .N(N),
        .WIDTH(WIDTH),
        .MAX_BURST(MAX_BURST),
        .GAP(GAP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .gnt(gnt),
        .in_en(in_en),
        .in_data(in_data),
        .out_en(out_en),
        .out_data(out_data),
        .burst_done(burst_done),
        .busy(busy)
`ifdef LPCM_ARBITER_STATS_EN
        ,
        .sample_cnt(sample_cnt)
`endif
    );

    typedef struct {
        int idx;
        int len;
    } burst_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    burst_t      bq[$];
    int          n_out = 0;

    int          src_left[N];
    int          src_k[N];
    logic [31:0] src_base[N];
    bit          src_junk[N];
    logic [N-1:0] acc = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Each source holds a sample until it is taken and drops req together with its last sample.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_junk[i]) begin
                req[i]                   = 1'b0;
                in_en[i]                 = 1'b1;
                in_data[i*WIDTH +: WIDTH] = JUNK;
            end else if (src_left[i] > 0) begin
                req[i]                   = (src_left[i] == 1) ? 1'b0 : 1'b1;
                in_en[i]                 = 1'b1;
                in_data[i*WIDTH +: WIDTH] = src_base[i] + 32'(src_k[i] + 1);
            end else begin
                req[i]                   = 1'b0;
                in_en[i]                 = 1'b0;
                in_data[i*WIDTH +: WIDTH] = '0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && src_left[i] > 0) begin
                src_left[i]--;
                src_k[i]++;
            end
        end
        drive();
    endtask

    task automatic set_src(input int i, input logic [31:0] base, input int n, input bit junk);
        src_base[i] = base;
        src_left[i] = n;
        src_k[i]    = 0;
        src_junk[i] = junk;
    endtask

    task automatic push_data(input logic [31:0] base, input int k1, input int k2);
        for (int k = k1; k <= k2; k++) exp_q.push_back(base + 32'(k));
    endtask

    task automatic push_burst(input int idx, input int len);
        burst_t b;
        b.idx = idx;
        b.len = len;
        bq.push_back(b);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        bq.delete();
        for (int i = 0; i < N; i++) set_src(i, '0, 0, 1'b0);
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bq.size() != 0) && t < 400) begin
            step();
            t++;
        end
        check({name, "_timeout"}, 64'(t >= 400), 64'd0);
        repeat (4) step();
        check({name, "_idle_busy"}, 64'(busy), 64'd0);
        check({name, "_idle_gnt"}, 64'(gnt), 64'd0);
    endtask

    int         cur_len = 0;
    int         cur_idx = 0;
    int         idle_cnt = 0;
    bit         seen_done = 1'b0;
    bit         prev_done = 1'b0;
    logic [N-1:0] prev_gnt = '0;

    always @(negedge clk) begin
        acc = gnt & in_en;
        if (!rst_n) begin
            cur_len   = 0;
            idle_cnt  = 0;
            seen_done = 1'b0;
            prev_done = 1'b0;
            prev_gnt  = '0;
            check("reset_burst_done", 64'(burst_done), 64'd0);
        end else begin
            check("gnt_onehot", 64'((gnt & (gnt - 1'b1)) != 0), 64'd0);
            if (gnt != 0) check("busy_in_grant", 64'(busy), 64'd1);
            if (out_en) begin
                n_out++;
                check("no_junk_out", 64'(out_data == JUNK), 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", 64'(out_data), 64'd0 - 64'd1);
                end else begin
                    check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
                end
                cur_len++;
            end else begin
                check("out_data_idle", 64'(out_data), 64'd0);
            end
            if (burst_done) begin
                check("done_single_pulse", 64'(prev_done), 64'd0);
                check("done_gnt_clear", 64'(gnt), 64'd0);
                if (bq.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    burst_t b;
                    b = bq.pop_front();
                    check("burst_idx", 64'(cur_idx), 64'(b.idx));
                    check("burst_len", 64'(cur_len), 64'(b.len));
                end
                seen_done = 1'b1;
                cur_len   = 0;
            end
            if (gnt != 0 && prev_gnt == 0) begin
                for (int i = 0; i < N; i++) if (gnt[i]) cur_idx = i;
                if (seen_done) check("gap_len", 64'(idle_cnt), 64'(GAP + 1));
                idle_cnt = 0;
            end else if (gnt == 0) begin
                idle_cnt++;
            end
            prev_gnt  = gnt;
            prev_done = burst_done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int t;
        for (int i = 0; i < N; i++) set_src(i, '0, 0, 1'b0);
        #1;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_out_en", 64'(out_en), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Single requester streaming: 4-sample burst, gap, regrant for the remaining two.
        do_reset();
        set_src(0, 32'h0, 6, 1'b0);
        push_data(32'h0, 1, 4); push_burst(0, 4);
        push_data(32'h0, 5, 6); push_burst(0, 2);
        drive();
        wait_done("t1");

        // Both streaming: bursts alternate 0,1,0,1,...
        do_reset();
        set_src(0, 32'h1000_0000, 16, 1'b0);
        set_src(1, 32'h2000_0000, 16, 1'b0);
        for (int b = 0; b < 4; b++) begin
            push_data(32'h1000_0000, 4*b + 1, 4*b + 4); push_burst(0, 4);
            push_data(32'h2000_0000, 4*b + 1, 4*b + 4); push_burst(1, 4);
        end
        drive();
        wait_done("t2");
`ifdef LPCM_ARBITER_STATS_EN
        check("stats_req0", 64'(sample_cnt[31:0]), 64'd16);
        check("stats_req1", 64'(sample_cnt[63:32]), 64'd16);
`endif

        // Requester 1 drops req with its 2nd sample; requester 0 follows.
        do_reset();
        set_src(0, 32'h3000_0000, 6, 1'b0);
        set_src(1, 32'h4000_0000, 2, 1'b0);
        push_data(32'h3000_0000, 1, 4); push_burst(0, 4);
        push_data(32'h4000_0000, 1, 2); push_burst(1, 2);
        push_data(32'h3000_0000, 5, 6); push_burst(0, 2);
        drive();
        wait_done("t3");

        // Non-granted strobe with junk data must never reach the channel.
        do_reset();
        set_src(0, 32'h5000_0000, 3, 1'b0);
        set_src(1, 32'h0, 0, 1'b1);
        push_data(32'h5000_0000, 1, 3); push_burst(0, 3);
        drive();
        wait_done("t4");

        // Reset in mid-burst after the 2nd output sample.
        do_reset();
        set_src(0, 32'h6000_0000, 8, 1'b0);
        set_src(1, 32'h7000_0000, 8, 1'b0);
        push_data(32'h6000_0000, 1, 4); push_burst(0, 4);
        drive();
        n0 = n_out;
        t  = 0;
        do begin
            step();
            @(negedge clk);
            #1;
            t++;
        end while (n_out < n0 + 2 && t < 50);
        check("t5_wait_timeout", 64'(t >= 50), 64'd0);
        rst_n = 1'b0;
        exp_q.delete();
        bq.delete();
        #1;
        check("t5_gnt", 64'(gnt), 64'd0);
        check("t5_out_en", 64'(out_en), 64'd0);
        check("t5_out_data", 64'(out_data), 64'd0);
        check("t5_burst_done", 64'(burst_done), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_src(0, 32'h8000_0000, 4, 1'b0);
        set_src(1, 32'h9000_0000, 4, 1'b0);
        push_data(32'h8000_0000, 1, 4); push_burst(0, 4);
        push_data(32'h9000_0000, 1, 4); push_burst(1, 4);
        drive();
        wait_done("t5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpcm_arbiter.md
LPCM_ARBITER -- requirements
Module: lpcm_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning the number of LPCM requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning the LPCM sample width.
REQ-003 The block SHALL have parameter MAX_BURST, default 16, meaning the maximum samples accepted per grant (1..255).
REQ-004 The block SHALL have parameter GAP, default 1, meaning the idle cycles forced after each burst (0..15).
REQ-005 Port clk  input  1  sole clock; all logic uses the rising edge.
REQ-006 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-007 Port req  input  N  per-requester request level.
REQ-008 Port gnt  output  N  one-hot grant, registered.
REQ-009 Port in_en  input  N  per-requester LPCM sample strobe.
REQ-010 Port in_data  input  N*WIDTH  per-requester LPCM sample; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-011 Port out_en  output  1  shared LPCM channel strobe, registered.
REQ-012 Port out_data  output  WIDTH  shared LPCM channel sample, registered.
REQ-013 Port burst_done  output  1  single-cycle pulse marking the end of a burst.
REQ-014 Port busy  output  1  high when the state is not IDLE.

Function
REQ-015 The block SHALL implement three states: IDLE, GRANT and GAP.
REQ-016 In IDLE with req != 0, the block SHALL select the first requester with req high, searching from ptr upward modulo N; at the next edge it SHALL set gnt to that one-hot value, load cnt=0 and enter GRANT.
REQ-017 In IDLE with req == 0, the block SHALL hold gnt=0 and remain in IDLE.
REQ-018 In GRANT, a sample SHALL be accepted when gnt[g] && in_en[g] are high; accepted samples SHALL appear on out_en=1 and out_data=in_data[g] one cycle later, giving 1-cycle latency.
REQ-019 When no sample is accepted in a cycle, the following cycle SHALL have out_en=0 and out_data=0.
REQ-020 in_en and in_data from non-granted requesters SHALL be ignored.
REQ-021 The burst SHALL end at the edge where the MAX_BURST-th sample is accepted, or at the first edge where req[g] is sampled low.
REQ-022 If req[g] is low while in_en[g] is high, that sample SHALL still be accepted and the burst SHALL end at the same edge.
REQ-023 At burst end, gnt SHALL clear, burst_done SHALL pulse high for the following cycle, and ptr SHALL become (g+1) mod N.
REQ-024 At burst end, the next state SHALL be GAP if GAP > 0, otherwise IDLE.
REQ-025 GAP SHALL last exactly GAP cycles with gnt=0, then the block SHALL enter IDLE.
REQ-026 cnt SHALL be $clog2(MAX_BURST+1) bits wide and SHALL never wrap within a burst.
REQ-027 At most one gnt bit SHALL be high in any cycle.
REQ-028 Every requester holding req continuously SHALL receive a grant within N bursts.

Reset
REQ-029 On rst_n low, the block SHALL immediately force state=IDLE, gnt=0, out_en=0, out_data=0, burst_done=0, busy=0, ptr=0 and cnt=0, including mid-burst.
REQ-030 After reset release, the first arbitration SHALL start on the first rising clk edge with rst_n high, with priority starting at requester 0.
REQ-031 A burst interrupted by reset SHALL produce no burst_done pulse.

Configuration
REQ-032 With macro LPCM_ARBITER_STATS_EN defined, the block SHALL add output sample_cnt (N*32 bits): per-requester saturating counters of accepted samples, reset to 0 by rst_n and held at 32'hFFFF_FFFF once reached.
REQ-033 Without LPCM_ARBITER_STATS_EN defined, the sample_cnt port and its counters SHALL be absent, and all other behaviour SHALL be identical.

Verification (N=2, WIDTH=32, MAX_BURST=4, GAP=1)
REQ-034 req=2'b01 held, in_en[0]=1 every cycle, data 1..6 -> out gives 1,2,3,4; burst_done pulse; 1 gap cycle; regrant to requester 0; out gives 5,6.
REQ-035 req=2'b11 held, both streaming -> bursts of 4 samples alternate 0,1,0,1; gnt is never 2'b11.
REQ-036 Requester 1 granted, req[1] drops with its 2nd sample -> 2 samples output, burst_done pulses, next grant goes to requester 0.
REQ-037 in_en[1]=1 with data 32'hDEAD_BEEF while requester 0 is granted -> 32'hDEAD_BEEF never appears on out_data.
REQ-038 rst_n asserted after the 2nd sample of a burst -> all outputs are 0 in the same cycle, no burst_done pulse; after release with req=2'b11, requester 0 is granted first.
REQ-039 With LPCM_ARBITER_STATS_EN defined, after REQ-035 runs for 8 bursts -> sample_cnt is 16 for each requester.
